// File: rtl/alu_mult_seq_pkg.sv
// Shared ALU opcode constants and state encoding for the shift-add multiply sequencer.
package alu_mult_seq_pkg;

   localparam int ALU_WIDTH = 32;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1100,
      ALU_SLL = 4'b1101,
      ALU_SRL = 4'b1110
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_TEST = 3'd1,
      ST_ADD  = 3'd2,
      ST_SHL  = 3'd3,
      ST_SHR  = 3'd4,
      ST_DONE = 3'd5
   } mult_state_e;

endpackage

// File: rtl/alu_32bit.sv
// Combinational 32-bit ALU shared with the multiply sequencer; shifts act on operand A.
module alu_32bit
   import alu_mult_seq_pkg::*;
(
   input  logic [3:0]           op,
   input  logic [ALU_WIDTH-1:0] first,
   input  logic [ALU_WIDTH-1:0] second,
   input  logic [4:0]           shamt,
   output logic [ALU_WIDTH-1:0] result,
   output logic                 zero
);

   logic slt;

   always_comb begin
      slt    = $signed(first) < $signed(second);
      result = '0;
      case (op)
         ALU_AND: result = first & second;
         ALU_OR:  result = first | second;
         ALU_ADD: result = first + second;
         ALU_SUB: result = first - second;
         ALU_SLT: result = {{(ALU_WIDTH-1){1'b0}}, slt};
         ALU_NOR: result = ~(first | second);
         ALU_SLL: result = first << shamt;
         ALU_SRL: result = first >> shamt;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/mult_unit.sv
// Integration wrapper pairing the multiply sequencer with the shared ALU.
module mult_unit
   import alu_mult_seq_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 flush,
   input  logic [ALU_WIDTH-1:0] mcand_in,
   input  logic [ALU_WIDTH-1:0] mplier_in,
   output logic                 busy,
   output logic                 done,
   output logic [ALU_WIDTH-1:0] product,
   output logic [5:0]           iter_count
);

   logic [3:0]           op;
   logic [ALU_WIDTH-1:0] first, second, result;
   logic [4:0]           shamt;
   logic                 zero;

   alu_mult_seq #(.WIDTH(ALU_WIDTH), .ITER_MAX(32)) u_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .flush      (flush),
      .mcand_in   (mcand_in),
      .mplier_in  (mplier_in),
      .busy       (busy),
      .done       (done),
      .product    (product),
      .iter_count (iter_count),
      .alu_op     (op),
      .alu_first  (first),
      .alu_second (second),
      .alu_shamt  (shamt),
      .alu_result (result),
      .alu_zero   (zero)
   );

   alu_32bit u_alu (
      .op     (op),
      .first  (first),
      .second (second),
      .shamt  (shamt),
      .result (result),
      .zero   (zero)
   );

endmodule

// File: rtl/alu_mult_seq.sv
// Multi-cycle shift-add multiplier that borrows the shared ALU, one ALU operation per cycle.
// Produces the low WIDTH bits of mcand*mplier.
module alu_mult_seq
   import alu_mult_seq_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int ITER_MAX = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] mcand_in,
   input  logic [WIDTH-1:0] mplier_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic [5:0]       iter_count,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_first,
   output logic [WIDTH-1:0] alu_second,
   output logic [4:0]       alu_shamt,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero
);

   localparam logic [5:0] ITER_LAST = 6'(ITER_MAX);
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   mult_state_e      state_q, state_d;
   logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
   logic             test_bit_q;
   logic [5:0]       iter_next;
   logic             abort;

   assign iter_next = iter_count + 6'd1;
   assign abort     = flush && (state_q != ST_IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every combinational output gets a default before the case so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_TEST;
         ST_TEST: state_d = alu_zero ? ST_SHL : ST_ADD;
         ST_ADD:  state_d = ST_SHL;
         ST_SHL:  state_d = ST_SHR;
         ST_SHR:  state_d = (alu_zero || iter_next == ITER_LAST) ? ST_DONE : ST_TEST;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
   end

   always_comb begin
      alu_op     = ALU_AND;
      alu_first  = '0;
      alu_second = '0;
      alu_shamt  = '0;
      busy       = (state_q != ST_IDLE);
      done       = (state_q == ST_DONE);
      unique case (state_q)
         ST_TEST: begin
            alu_op     = ALU_AND;
            alu_first  = mplier_q;
            alu_second = ONE;
         end
         ST_ADD: begin
            alu_op     = ALU_ADD;
            alu_first  = acc_q;
            // The addend is gated by the tested bit; ADD is only entered when it is set.
            alu_second = test_bit_q ? mcand_q : '0;
         end
         ST_SHL: begin
            alu_op    = ALU_SLL;
            alu_first = mcand_q;
            alu_shamt = 5'd1;
         end
         ST_SHR: begin
            alu_op    = ALU_SRL;
            alu_first = mplier_q;
            alu_shamt = 5'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         test_bit_q <= 1'b0;
         product    <= '0;
         iter_count <= '0;
      end else if (!abort) begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  mcand_q    <= mcand_in;
                  mplier_q   <= mplier_in;
                  acc_q      <= '0;
                  test_bit_q <= 1'b0;
                  iter_count <= '0;
               end
            end
            ST_TEST: test_bit_q <= ~alu_zero;
            ST_ADD:  acc_q      <= alu_result;
            ST_SHL:  mcand_q    <= alu_result;
            ST_SHR: begin
               mplier_q   <= alu_result;
               iter_count <= iter_next;
               // Product is captured on the edge entering DONE so it is valid with the pulse.
               if (state_d == ST_DONE) product <= acc_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq: behavioural ALU, product/latency/iteration model, random and directed runs.
module tb_alu_mult_seq;

   localparam int EV_NONE  = 0;
   localparam int EV_START = 1;
   localparam int EV_FLUSH = 2;
   localparam int EV_RESET = 3;
   localparam int MAX_CYC  = 200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] mcand_in = '0;
   logic [31:0] mplier_in = '0;
   logic        busy, done;
   logic [31:0] product;
   logic [5:0]  iter_count;
   logic [3:0]  alu_op;
   logic [31:0] alu_first, alu_second, alu_result;
   logic [4:0]  alu_shamt;
   logic        alu_zero;

   int n_checks = 0;
   int n_errors = 0;
   logic [3:0] ops[$];
   logic [3:0] exp_ops[$];
   logic [31:0] last_product = '0;

   always #5 clk = ~clk;

   alu_mult_seq #(.WIDTH(32), .ITER_MAX(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .flush      (flush),
      .mcand_in   (mcand_in),
      .mplier_in  (mplier_in),
      .busy       (busy),
      .done       (done),
      .product    (product),
      .iter_count (iter_count),
      .alu_op     (alu_op),
      .alu_first  (alu_first),
      .alu_second (alu_second),
      .alu_shamt  (alu_shamt),
      .alu_result (alu_result),
      .alu_zero   (alu_zero)
   );

   // Behavioural stand-in for the external ALU, opcodes written out as plain constants.
   always_comb begin
      alu_result = '0;
      case (alu_op)
         4'b0000: alu_result = alu_first & alu_second;
         4'b0001: alu_result = alu_first | alu_second;
         4'b0010: alu_result = alu_first + alu_second;
         4'b0110: alu_result = alu_first - alu_second;
         4'b1100: alu_result = ~(alu_first | alu_second);
         4'b1101: alu_result = alu_first << alu_shamt;
         4'b1110: alu_result = alu_first >> alu_shamt;
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   function automatic int exp_iters(input logic [31:0] v);
      int n = 0;
      for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
      return (n == 0) ? 1 : n;
   endfunction

   function automatic int exp_latency(input logic [31:0] v);
      return 1 + 3 * exp_iters(v) + $countones(v);
   endfunction

   function automatic logic [31:0] exp_product(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] full;
      full = {32'd0, a} * {32'd0, b};
      return full[31:0];
   endfunction

   // Expected ALU opcode trace: per multiplier bit a test, an optional add, then two shifts.
   task automatic build_exp_ops(input logic [31:0] b);
      logic [31:0] v;
      int n;
      v = b;
      n = 0;
      exp_ops.delete();
      do begin
         exp_ops.push_back(4'b0000);
         if (v[0]) exp_ops.push_back(4'b0010);
         exp_ops.push_back(4'b1101);
         exp_ops.push_back(4'b1110);
         v = v >> 1;
         n++;
      end while (v != 0 && n < 32);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input int ev_cyc, input int ev_kind,
                         output int end_cyc, output bit saw_done, output bit busy_c1,
                         output logic [31:0] prod, output logic [5:0] iters);
      int  guard;
      int  cyc;
      bit  stop;
      saw_done = 1'b0;
      busy_c1  = 1'b0;
      end_cyc  = -1;
      prod     = '0;
      iters    = '0;
      ops.delete();
      guard = 0;
      @(negedge clk);
      while (busy && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      mcand_in  = a;
      mplier_in = b;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc   = 1;
      stop  = 1'b0;
      busy_c1 = busy;
      while (!stop && cyc <= MAX_CYC) begin
         if (done) begin
            saw_done = 1'b1;
            end_cyc  = cyc;
            prod     = product;
            iters    = iter_count;
            stop     = 1'b1;
         end else if (!busy) begin
            end_cyc = cyc;
            stop    = 1'b1;
         end else begin
            ops.push_back(alu_op);
            if (cyc == ev_cyc && ev_kind == EV_RESET) begin
               rst_n = 1'b0;
               #1;
               end_cyc = cyc;
               stop    = 1'b1;
            end else begin
               if (cyc == ev_cyc && ev_kind == EV_START) begin
                  mcand_in  = 32'd9;
                  mplier_in = 32'd9;
                  start     = 1'b1;
               end
               if (cyc == ev_cyc && ev_kind == EV_FLUSH) flush = 1'b1;
               @(posedge clk);
               #1;
               start = 1'b0;
               flush = 1'b0;
               cyc++;
            end
         end
      end
      if (saw_done) last_product = exp_product(a, b);
   endtask

   task automatic test_reset;
      #3;
      n_checks++; if (busy !== 1'b0)      begin n_errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      n_checks++; if (done !== 1'b0)      begin n_errors++; $display("FAIL reset_done: got %0b expected 0", done); end
      n_checks++; if (product !== 32'd0)  begin n_errors++; $display("FAIL reset_product: got %0h expected 0", product); end
      n_checks++; if (iter_count !== 6'd0) begin n_errors++; $display("FAIL reset_iter: got %0d expected 0", iter_count); end
      n_checks++; if (alu_op !== 4'b0000) begin n_errors++; $display("FAIL reset_alu_op: got %0h expected 0", alu_op); end
      n_checks++;
      if (alu_first !== 32'd0 || alu_second !== 32'd0 || alu_shamt !== 5'd0) begin
         n_errors++;
         $display("FAIL reset_alu_operands: got %0h/%0h/%0d expected 0/0/0", alu_first, alu_second, alu_shamt);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_run(input string name, input logic [31:0] a, input logic [31:0] b,
                            input int end_cyc, input bit saw_done,
                            input logic [31:0] prod, input logic [5:0] iters);
      n_checks++;
      if (!saw_done || end_cyc != exp_latency(b)) begin
         n_errors++;
         $display("FAIL %s_latency: got done=%0b cycle %0d expected cycle %0d", name, saw_done, end_cyc, exp_latency(b));
      end
      n_checks++;
      if (prod !== exp_product(a, b)) begin
         n_errors++;
         $display("FAIL %s_product: %0h*%0h got %0h expected %0h", name, a, b, prod, exp_product(a, b));
      end
      n_checks++;
      if (iters !== 6'(exp_iters(b))) begin
         n_errors++;
         $display("FAIL %s_iters: got %0d expected %0d", name, iters, exp_iters(b));
      end
   endtask

   task automatic test_basic;
      int ec; bit sd, b1; logic [31:0] p; logic [5:0] it;
      run_op(32'd5, 32'd17, 0, EV_NONE, ec, sd, b1, p, it);
      n_checks++; if (b1 !== 1'b1) begin n_errors++; $display("FAIL basic_busy_c1: got %0b expected 1", b1); end
      check_run("basic", 32'd5, 32'd17, ec, sd, p, it);
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL basic_pulse: got done=%0b busy=%0b expected 0/0", done, busy);
      end
   endtask

   task automatic test_zero_mplier;
      int ec; bit sd, b1; logic [31:0] p; logic [5:0] it;
      run_op(32'd123, 32'd0, 0, EV_NONE, ec, sd, b1, p, it);
      check_run("zero", 32'd123, 32'd0, ec, sd, p, it);
      n_checks++;
      if (ops.size() != 3 || ops[0] !== 4'b0000 || ops[1] !== 4'b1101 || ops[2] !== 4'b1110) begin
         n_errors++;
         $display("FAIL zero_op_seq: got %0d ops expected AND,SLL,SRL", ops.size());
      end
   endtask

   task automatic test_max;
      int ec; bit sd, b1; logic [31:0] p; logic [5:0] it;
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, EV_NONE, ec, sd, b1, p, it);
      check_run("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, ec, sd, p, it);
   endtask

   task automatic test_random;
      int ec; bit sd, b1; logic [31:0] p; logic [5:0] it;
      logic [31:0] a, b;
      bit ops_ok;
      for (int n = 0; n < 16; n++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if (n == 3) b = 32'd0;
         run_op(a, b, 0, EV_NONE, ec, sd, b1, p, it);
         check_run("random", a, b, ec, sd, p, it);
         build_exp_ops(b);
         ops_ok = (ops.size() == exp_ops.size());
         for (int i = 0; i < ops.size() && ops_ok; i++) if (ops[i] !== exp_ops[i]) ops_ok = 1'b0;
         n_checks++;
         if (!ops_ok) begin
            n_errors++;
            $display("FAIL random_op_seq: mplier %0h got %0d ops expected %0d", b, ops.size(), exp_ops.size());
         end
      end
   endtask

   task automatic test_start_ignored;
      int ec; bit sd, b1; logic [31:0] p; logic [5:0] it;
      run_op(32'd6, 32'd7, 5, EV_START, ec, sd, b1, p, it);
      check_run("busy_start", 32'd6, 32'd7, ec, sd, p, it);
      run_op(32'd9, 32'd9, 0, EV_NONE, ec, sd, b1, p, it);
      check_run("after_ignore", 32'd9, 32'd9, ec, sd, p, it);
   endtask

   task automatic test_flush;
      int ec; bit sd, b1; logic [31:0] p; logic [5:0] it;
      logic [31:0] held;
      run_op(32'd6, 32'd7, 0, EV_NONE, ec, sd, b1, p, it);
      check_run("pre_flush", 32'd6, 32'd7, ec, sd, p, it);
      held = last_product;
      run_op(32'd5, 32'd17, 8, EV_FLUSH, ec, sd, b1, p, it);
      n_checks++; if (sd !== 1'b0) begin n_errors++; $display("FAIL flush_no_done: got done seen %0b expected 0", sd); end
      n_checks++; if (ec != 9) begin n_errors++; $display("FAIL flush_idle_cycle: got %0d expected 9", ec); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL flush_busy: got %0b expected 0", busy); end
      n_checks++; if (product !== held) begin n_errors++; $display("FAIL flush_product: got %0d expected %0d", product, held); end
      n_checks++; if (iter_count !== 6'd2) begin n_errors++; $display("FAIL flush_iter: got %0d expected 2", iter_count); end
   endtask

   task automatic test_reset_mid;
      int ec; bit sd, b1; logic [31:0] p; logic [5:0] it;
      run_op(32'd5, 32'd17, 6, EV_RESET, ec, sd, b1, p, it);
      n_checks++; if (sd !== 1'b0) begin n_errors++; $display("FAIL rst_mid_no_done: got %0b expected 0", sd); end
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0 || iter_count !== 6'd0 || alu_op !== 4'b0000) begin
         n_errors++;
         $display("FAIL rst_mid_state: got busy=%0b done=%0b product=%0h iter=%0d op=%0h expected 0 0 0 0 0",
                  busy, done, product, iter_count, alu_op);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'd5, 32'd17, 0, EV_NONE, ec, sd, b1, p, it);
      check_run("rst_restart", 32'd5, 32'd17, ec, sd, p, it);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_mplier();
      test_max();
      test_random();
      test_start_ignored();
      test_flush();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no completion expected summary");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
- Multi-cycle multiply sequencer that borrows the shared 32-bit ALU and drives it with AND/ADD/SLL/SRL operations to form a shift-add product.
- Produces the low 32 bits of a 32x32 multiply for the MIPS mult/mul path.
- One ALU operation is issued per cycle. The ALU is combinational and external; this block only drives its inputs and registers its outputs.

Parameters:
- WIDTH, 32, datapath width; fixed by the ALU and must not be overridden.
- ITER_MAX, 32, hard cap on shift-add iterations, used as a safety bound.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a multiply; sampled only in IDLE.
- flush  in  1  synchronous abort; returns to IDLE, product unchanged.
- mcand_in  in  32  multiplicand, latched on an accepted start.
- mplier_in  in  32  multiplier, latched on an accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when product is valid.
- product  out  32  low 32 bits of mcand*mplier; held until the next completion.
- iter_count  out  6  iterations completed in the current or last operation.
- alu_op  out  4  ALU opcode.
- alu_first  out  32  ALU operand A.
- alu_second  out  32  ALU operand B.
- alu_shamt  out  5  ALU shift amount.
- alu_result  in  32  ALU result.
- alu_zero  in  1  ALU zero flag.

Behaviour:
- Reset: asynchronous on rst_n low.
  - State goes to IDLE; all internal registers clear: acc, mcand, mplier, bit.
  - busy=0, done=0, product=0, iter_count=0.
- ALU outputs are registered-state-driven combinational decodes:
  - IDLE and DONE: op=AND, first=0, second=0, shamt=0.
- States:
  - IDLE:
    - start=1 latches mcand_in and mplier_in, clears acc and iter_count, then goes to TEST.
  - TEST:
    - Drive op=AND, first=mplier, second=1.
    - Register bit=~alu_zero.
    - Go to ADD if bit is 1, else go to SHL.
  - ADD:
    - Drive op=ADD, first=acc, second=mcand.
    - Set acc<=alu_result, then go to SHL.
  - SHL:
    - Drive op=SLL, first=mcand, shamt=1.
    - Set mcand<=alu_result, then go to SHR.
  - SHR:
    - Drive op=SRL, first=mplier, shamt=1.
    - Set mplier<=alu_result and iter_count+1.
    - Go to DONE if alu_zero or iter_count+1==ITER_MAX, else go to TEST.
  - DONE:
    - done=1 for this single cycle; product<=acc is registered on entry.
    - Go to IDLE next cycle.
- Latency: start sampled at edge 0, and done is high in cycle 1 + 3*k + p.
  - k = max(1, bit-length of mplier); p = popcount(mplier).
  - Minimum is 4 cycles; maximum is 129 cycles.
- Arithmetic: unsigned modulo 2^32; carries out of bit 31 are dropped. The low word is also correct for two's-complement signed operands.
- start while busy: ignored; latched operands are unaffected.
- flush: honoured in any non-IDLE state and has priority over the next-state logic.
  - Goes to IDLE next edge with no done pulse; product and iter_count are held.
- flush and start in the same IDLE cycle: start wins, since flush is a no-op in IDLE.
- Reset mid-operation: immediate return to the reset values; no done pulse.
- mplier_in=0: executes one iteration (TEST, SHL, SHR), then DONE with product=0.

Decomposition:
- Shared package/include alu_defs.v holds the ALU opcode constants:
  - ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110.
  - ALU_SLT=4'b0111, ALU_NOR=4'b1100, ALU_SLL=4'b1101, ALU_SRL=4'b1110.
- The package also holds the state encodings for alu_mult_seq.
- Single FSM module with no sub-module.
- Bench/integration wrapper mult_unit instantiates alu_mult_seq together with alu_32bit, wiring (zero, result, first, second, op, shamt).

Test Plan:
- mcand=5, mplier=17, start for 1 cycle -> busy next cycle; done pulse in cycle 18; product=85; iter_count=5.
- mcand=123, mplier=0 -> done in cycle 4; product=0; iter_count=1; alu_op sequence AND, SLL, SRL.
- mcand=0xFFFFFFFF, mplier=0xFFFFFFFF -> done in cycle 129; product=0x00000001; iter_count=32.
- 6*7 running; pulse start with 9*9 in cycle 5 -> ignored; product=42 at done; a subsequent start then yields 81.
- 5*17 running; flush in cycle 8 -> IDLE at cycle 9; no done; product keeps prior value 42; busy=0.
- 5*17 running; rst_n low in cycle 6 -> immediate busy=0, product=0, iter_count=0, alu_op=AND; restart gives 85 in cycle 18 after the new start.
